fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//   Parametrised instruction-fetch front end: owns the PC, issues requests to a
//   1-cycle synchronous instruction memory, buffers returned words in a DEPTH-entry
//   prefetch FIFO and hands {pc, instruction} to the decoder via valid/ready.
//   Replaces the free-running PC + adder pair; adds stall, redirect (branch/jump) and flush.
// PARAMETERS
//   ADDR_W   32  PC / memory address width
//   DATA_W   32  instruction word width
//   DEPTH    4   prefetch FIFO entries (>=2, power of 2)
//   RESET_PC 0   PC loaded on reset
//   PC_STEP  4   PC increment per fetched word
// PORTS
//   clk            in   1       clock, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   imem_req       out  1       fetch request this cycle
//   imem_addr      out  ADDR_W  fetch address (= pc)
//   imem_rvalid    in   1       response valid, exactly 1 cycle after imem_req
//   imem_rdata     in   DATA_W  response instruction word
//   redirect_valid in   1       load new PC, flush queue
//   redirect_pc    in   ADDR_W  redirect target; low 2 bits forced to 0
//   inst_valid     out  1       FIFO head valid (count != 0)
//   inst_ready     in   1       decoder accepts head
//   inst_data      out  DATA_W  head instruction
//   inst_pc        out  ADDR_W  address of head instruction
// BEHAVIOUR
//   - Reset: pc=RESET_PC, state=BOOT, count=0, inflight=0; imem_req=0, inst_valid=0,
//     inst_data=0, inst_pc=0. Async assert; first edge after release: BOOT->FETCH.
//   - FSM: BOOT->FETCH; FETCH->HOLD when count+inflight==DEPTH;
//     HOLD->FETCH when count+inflight<DEPTH; any state + redirect_valid -> FETCH.
//   - imem_req = (state==FETCH) & (count+inflight<DEPTH) & !redirect_valid;
//     imem_addr=pc. On issue: pc <= pc+PC_STEP (mod 2^ADDR_W, wraps silently),
//     inflight<=1 and the issued address is held for the response.
//   - Response (imem_rvalid): push {addr, rdata} at tail unless dropped (below).
//     Credit scheme guarantees no push when full; push while full is a bench assertion.
//   - Latency: request cycle t -> inst_valid at t+2 (no bypass). Steady state with
//     inst_ready=1: one instruction per cycle.
//   - Pop on inst_valid & inst_ready. Push and pop same cycle: count unchanged.
//   - Empty: inst_valid=0, inst_data/inst_pc hold last value. Full: no new request.
//   - Redirect cycle: pc<=redirect_pc&~3, count<=0, head/tail<=0, inflight<=0;
//     response arriving this cycle is discarded; no request issued; a pop handshake
//     in the same cycle still counts as accepted. First new request next cycle.
//   - Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
//   - Reset mid-operation: all state cleared immediately; late imem_rvalid ignored
//     while rst_n low.
// CONFIGURATION
//   FETCH_QUEUE_STATS_EN defined: adds outputs stat_fetched[31:0] (increments on each
//     accepted push) and stat_flushed[31:0] (adds entries discarded by redirect,
//     including a dropped response); both reset to 0, wrap at 2^32.
//   Undefined: ports and counters absent; functional behaviour identical.
// TESTING
//   1. Reset release, inst_ready=1, mem returns addr>>2 -> requests 0,4,8..; first
//      inst_valid 2 cycles after first req with inst_pc=0, then one word/cycle.
//   2. inst_ready=0 for 10 cycles -> exactly DEPTH=4 reqs (0..12), FSM in HOLD,
//      count=4; raise ready -> pops pc 0,4,8,12 in order, fetching resumes at 16.
//   3. redirect_valid with redirect_pc=0x103 while 3 queued + 1 inflight ->
//      next cycle count=0, inst_valid=0, imem_addr=0x100; old response never appears.
//   4. redirect_valid and pop handshake same cycle -> popped word counted once,
//      queue empty next cycle, fetch restarts at redirect_pc.
//   5. RESET_PC=32'hFFFF_FFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
//   6. rst_n pulsed low mid-stream -> outputs zero asynchronously; restart at RESET_PC;
//      with FETCH_QUEUE_STATS_EN, counters read 0 then track pushes/flushes exactly.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch front end. Owns the PC, issues one request per cycle to a
//   synchronous instruction memory with fixed 1-cycle response latency, buffers
//   returned words with their addresses in a DEPTH-entry prefetch FIFO and
//   presents the FIFO head to the decoder through a valid/ready handshake.
//   A redirect reloads the PC (word aligned) and flushes everything in flight.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and its address (current PC)
//   imem_rvalid/rdata response, one cycle after the matching request
//   redirect_valid/pc new PC load + queue flush (low two bits of target ignored)
//   inst_valid/ready  decoder handshake on the FIFO head
//   inst_data/pc      head instruction and its address (hold last popped when empty)
//
// Optional build macro FETCH_QUEUE_STATS_EN adds:
//   stat_fetched      count of words pushed into the FIFO
//   stat_flushed      count of words discarded by redirects (queued + dropped response)

module fetch_queue_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_flushed
`endif
);

    // state | meaning
    // BOOT  | first cycle after reset, no request
    // FETCH | issuing one request per cycle while credit remains
    // HOLD  | queue plus in-flight word fills DEPTH, waiting for a pop
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int unsigned       PW        = $clog2(DEPTH);
    localparam int unsigned       CW        = PW + 1;
    localparam logic [CW:0]       DEPTH_C   = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP_C = ADDR_W'(PC_STEP);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic              inflight_q;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [DATA_W-1:0] last_data_q;
    logic [ADDR_W-1:0] last_pc_q;

    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];

    logic [CW:0]       occupancy;
    logic              has_credit;
    logic              push;
    logic              pop;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Credit = words already queued plus the one possibly on its way back.
    // Never issuing past DEPTH guarantees a response always finds a free slot.
    assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign has_credit = occupancy < DEPTH_C;

    assign imem_req   = (state_q == ST_FETCH) && has_credit && !redirect_valid;
    assign imem_addr  = pc_q;

    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? fifo_data[head_q] : last_data_q;
    assign inst_pc    = inst_valid ? fifo_pc[head_q]   : last_pc_q;

    // A response is only meaningful if we actually have a request outstanding;
    // one arriving during a redirect belongs to the abandoned path.
    assign push = imem_rvalid && inflight_q && !redirect_valid;
    assign pop  = inst_valid && inst_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (!has_credit) state_d = ST_HOLD;
            ST_HOLD:  if (has_credit)  state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase

        if (imem_req) pc_d   = pc_q + PC_STEP_C;
        if (push)     tail_d = tail_q + 1'b1;
        if (pop)      head_d = head_q + 1'b1;

        if (redirect_valid) begin
            state_d = ST_FETCH;
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            req_addr_q  <= '0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            last_data_q <= '0;
            last_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            // Response latency is exactly one cycle, so what is in flight next
            // cycle is simply whether we issue now.
            inflight_q <= imem_req;
            if (imem_req) begin
                req_addr_q <= pc_q;
            end
            if (pop) begin
                last_data_q <= fifo_data[head_q];
                last_pc_q   <= fifo_pc[head_q];
            end
        end
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[tail_q] <= imem_rdata;
            fifo_pc[tail_q]   <= req_addr_q;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;
    logic        drop;
    logic [CW:0] discarded;

    // A word popped in the redirect cycle was delivered, so it is not flushed.
    assign drop      = imem_rvalid && inflight_q && redirect_valid;
    assign discarded = {1'b0, count_q} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, drop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (push) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (redirect_valid) begin
                flushed_q <= flushed_q + 32'(discarded);
            end
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
`timescale 1ns/1ps

module tb_fetch_queue_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [31:0] w_pc;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_fetched, stat_flushed;
    logic [31:0] w_stat_fetched, w_stat_flushed;
`endif

    fetch_queue_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_QUEUE_STATS_EN
        , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
    );

    fetch_queue_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .inst_valid(w_valid), .inst_ready(w_ready),
        .inst_data(w_data), .inst_pc(w_pc)
`ifdef FETCH_QUEUE_STATS_EN
        , .stat_fetched(w_stat_fetched), .stat_flushed(w_stat_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered queue of {pc, data} the decoder should see.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      q[$];
    logic        pend_req;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    logic [31:0] last_pc, last_data;
    logic [31:0] salt;
    int unsigned m_fetched, m_flushed;
    int          errors, checks, cyc;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_data;

    logic        w_pend;
    logic [31:0] w_pend_addr;
    logic [31:0] w_reqs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    task automatic model_reset();
        q.delete();
        pend_req    = 1'b0;
        pend_addr   = '0;
        exp_pc      = 32'h0;
        last_pc     = '0;
        last_data   = '0;
        m_fetched   = 0;
        m_flushed   = 0;
        w_pend      = 1'b0;
        w_pend_addr = '0;
        w_reqs.delete();
    endtask

    // One clock cycle: drive inputs at the falling edge, observe 1ns later,
    // then advance the model to the state after the next rising edge.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        entry_t e;
        @(negedge clk);
        imem_rvalid    = pend_req;
        imem_rdata     = pend_req ? mem_word(pend_addr) : $urandom;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        w_rvalid       = w_pend;
        w_rdata        = w_pend_addr >> 2;
        w_ready        = 1'b1;
        w_redirect     = 1'b0;
        w_redirect_pc  = '0;
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = inst_valid;
        obs_pc    = inst_pc;
        obs_data  = inst_data;

        checks++;
        if (inst_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL valid: inst_valid=%b expected %b (cycle %0d)", inst_valid, q.size() != 0, cyc);
        end
        checks++;
        if (q.size() != 0) begin
            if (inst_pc !== q[0].pc || inst_data !== q[0].data) begin
                errors++;
                $display("FAIL head: pc=%h data=%h expected pc=%h data=%h (cycle %0d)",
                         inst_pc, inst_data, q[0].pc, q[0].data, cyc);
            end
        end else begin
            if (inst_pc !== last_pc || inst_data !== last_data) begin
                errors++;
                $display("FAIL hold: pc=%h data=%h expected pc=%h data=%h (cycle %0d)",
                         inst_pc, inst_data, last_pc, last_data, cyc);
            end
        end
        checks++;
        if ($isunknown(imem_req)) begin
            errors++;
            $display("FAIL req_known: imem_req=%b expected 0 or 1 (cycle %0d)", imem_req, cyc);
        end
        if (imem_req === 1'b1) begin
            checks++;
            if (redir || (q.size() + pend_req) >= DEPTH) begin
                errors++;
                $display("FAIL credit: request with queued=%0d inflight=%0d redirect=%b (cycle %0d)",
                         q.size(), pend_req, redir, cyc);
            end
            checks++;
            if (imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_addr: addr=%h expected %h (cycle %0d)", imem_addr, exp_pc, cyc);
            end
        end

        if (q.size() != 0 && rdy) begin
            e         = q.pop_front();
            last_pc   = e.pc;
            last_data = e.data;
        end
        if (redir) begin
            m_flushed += q.size() + pend_req;
            q.delete();
            exp_pc = rpc & ~32'h3;
        end else if (pend_req) begin
            checks++;
            if (q.size() >= DEPTH) begin
                errors++;
                $display("FAIL overflow: push with %0d queued, limit %0d (cycle %0d)", q.size(), DEPTH, cyc);
            end
            e.pc   = pend_addr;
            e.data = mem_word(pend_addr);
            q.push_back(e);
            m_fetched++;
        end
        if (imem_req === 1'b1) exp_pc = exp_pc + 32'd4;
        pend_req  = (imem_req === 1'b1);
        pend_addr = imem_addr;

        if (w_req === 1'b1) w_reqs.push_back(w_addr);
        w_pend      = (w_req === 1'b1);
        w_pend_addr = w_addr;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        w_rvalid       = 1'b1;
        w_rdata        = 32'hDEAD_BEEF;
        w_ready        = 1'b1;
        w_redirect     = 1'b0;
        w_redirect_pc  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b valid=%b data=%h pc=%h expected all zero",
                     imem_req, inst_valid, inst_data, inst_pc);
        end
        checks++;
        if (imem_addr !== 32'h0 || w_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL reset_pc: addr=%h wrap_addr=%h expected 00000000/fffffff8", imem_addr, w_addr);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b0;
        w_rvalid    = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, 32'h0);
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'(4 * c)) begin
                errors++;
                $display("FAIL stream_req: req=%b addr=%h expected 1/%h", obs_req, obs_addr, 32'(4 * c));
            end
            checks++;
            if (c >= 2) begin
                if (obs_valid !== 1'b1 || obs_pc !== 32'(4 * (c - 2))) begin
                    errors++;
                    $display("FAIL stream_out: valid=%b pc=%h expected 1/%h", obs_valid, obs_pc, 32'(4 * (c - 2)));
                end
            end else if (obs_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_latency: valid=%b expected 0 in cycle %0d after boot", obs_valid, c);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        checks++;
        if (w_reqs.size() < 3) begin
            errors++;
            $display("FAIL wrap_count: %0d requests expected at least 3", w_reqs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (w_reqs[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_addr: request %0d addr=%h expected %h", i, w_reqs[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          n;
        logic        seen;
        logic [31:0] first_addr;
        step(1'b0, 1'b1, 32'h0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 32'h0);
            if (obs_req === 1'b1) n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL bp_reqcount: %0d requests while stalled expected %0d", n, DEPTH);
        end
        checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_full: req=%b valid=%b pc=%h expected 0/1/00000000", obs_req, obs_valid, obs_pc);
        end
        seen = 1'b0;
        first_addr = '0;
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1, 1'b0, 32'h0);
            checks++;
            if (obs_valid !== 1'b1 || obs_pc !== 32'(4 * k)) begin
                errors++;
                $display("FAIL bp_pop: valid=%b pc=%h expected 1/%h", obs_valid, obs_pc, 32'(4 * k));
            end
            if (!seen && obs_req === 1'b1) begin
                seen = 1'b1;
                first_addr = obs_addr;
            end
        end
        for (int c = 0; c < 10 && !seen; c++) begin
            step(1'b1, 1'b0, 32'h0);
            if (obs_req === 1'b1) begin
                seen = 1'b1;
                first_addr = obs_addr;
            end
        end
        checks++;
        if (!seen || first_addr !== 32'h10) begin
            errors++;
            $display("FAIL bp_resume: seen=%b addr=%h expected 1/00000010", seen, first_addr);
        end
    endtask

    task automatic test_redirect_flush();
        step(1'b0, 1'b1, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h103);
        checks++;
        if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_setup: valid=%b req=%b expected 1/0", obs_valid, obs_req);
        end
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h100) begin
            errors++;
            $display("FAIL flush_restart: valid=%b req=%b addr=%h expected 0/1/00000100",
                     obs_valid, obs_req, obs_addr);
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0, 32'h0);
            if (obs_valid === 1'b1) begin
                checks++;
                if (obs_pc < 32'h100) begin
                    errors++;
                    $display("FAIL flush_stale: pc=%h expected >= 00000100", obs_pc);
                end
            end
        end
    endtask

    task automatic test_redirect_pop();
        int unsigned fl0;
        step(1'b0, 1'b1, 32'h200);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        fl0 = m_flushed;
        step(1'b1, 1'b1, 32'h340);
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h200) begin
            errors++;
            $display("FAIL rpop_accept: valid=%b pc=%h expected 1/00000200", obs_valid, obs_pc);
        end
        checks++;
        if (m_flushed - fl0 != 2) begin
            errors++;
            $display("FAIL rpop_flushcount: %0d discarded expected 2", m_flushed - fl0);
        end
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h340 || obs_pc !== 32'h200) begin
            errors++;
            $display("FAIL rpop_restart: valid=%b req=%b addr=%h pc=%h expected 0/1/00000340/00000200",
                     obs_valid, obs_req, obs_addr, obs_pc);
        end
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h344) begin
            errors++;
            $display("FAIL rpop_next: req=%b addr=%h expected 1/00000344", obs_req, obs_addr);
        end
    endtask

    task automatic test_stats();
`ifdef FETCH_QUEUE_STATS_EN
        @(posedge clk);
        #1;
        checks++;
        if (stat_fetched !== m_fetched || stat_flushed !== m_flushed) begin
            errors++;
            $display("FAIL stats: fetched=%0d flushed=%0d expected %0d/%0d",
                     stat_fetched, stat_flushed, m_fetched, m_flushed);
        end
`endif
    endtask

    task automatic test_random();
        int pops;
        logic rdy, redir;
        pops = 0;
        for (int c = 0; c < 400; c++) begin
            rdy   = ($urandom_range(0, 99) < 70);
            redir = ($urandom_range(0, 99) < 4);
            step(rdy, redir, $urandom);
            if (obs_valid === 1'b1 && rdy) pops++;
        end
        checks++;
        if (pops < 50) begin
            errors++;
            $display("FAIL random_activity: %0d pops expected at least 50", pops);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 20; c++) step(($urandom_range(0, 1) == 1), 1'b0, 32'h0);
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        imem_rvalid = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 ||
            inst_pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: req=%b valid=%b data=%h pc=%h addr=%h expected all zero",
                     imem_req, inst_valid, inst_data, inst_pc, imem_addr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b0;
        w_rvalid    = 1'b0;
        model_reset();
`ifdef FETCH_QUEUE_STATS_EN
        #1;
        checks++;
        if (stat_fetched !== 32'h0 || stat_flushed !== 32'h0) begin
            errors++;
            $display("FAIL midreset_stats: fetched=%0d flushed=%0d expected 0/0", stat_fetched, stat_flushed);
        end
`endif
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: req=%b addr=%h valid=%b expected 1/00000000/0",
                     obs_req, obs_addr, obs_valid);
        end
        for (int c = 0; c < 30; c++) step(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0), $urandom);
        test_stats();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        salt   = $urandom;
        model_reset();
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure();
        test_redirect_flush();
        test_redirect_pop();
        test_stats();
        test_random();
        test_stats();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
